// File: rtl/priority_arbiter8.sv
// rtl/priority_arbiter8.sv - 8-way request arbiter with fixed/round-robin priority and hold timeout

module priority_arbiter8 #(
  parameter int RR_EN    = 0,
  parameter int MAX_HOLD = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] grant_id,
  output logic       grant_valid,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Hold counter is zero-based, so the last permitted held cycle is MAX_HOLD-1.
  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

  state_t     state, state_n;
  logic [7:0] grant_n;
  logic [2:0] grant_id_n;
  logic       grant_valid_n;
  logic       timeout_n;
  logic [7:0] hold_cnt, hold_cnt_n;
  logic [7:0] mask, mask_n;
  logic [2:0] last_id, last_id_n;

  logic [7:0] eligible;
  logic       any_eligible;
  logic [2:0] winner;
  logic       found;
  logic [2:0] probe;

  // Winner search: lowest index in fixed mode, or first eligible after last_id in rotation mode.
  always_comb begin
    eligible     = req & ~mask;
    any_eligible = |eligible;
    winner       = 3'd0;
    found        = 1'b0;
    probe        = 3'd0;
    for (int k = 0; k < 8; k++) begin
      probe = (RR_EN != 0) ? (last_id + 3'(k + 1)) : 3'(k);
      if (!found && eligible[probe]) begin
        winner = probe;
        found  = 1'b1;
      end
    end
  end

  // Next-state and next-output logic; masks clear on any cycle the requester is low.
  always_comb begin
    state_n       = state;
    grant_n       = grant;
    grant_id_n    = grant_id;
    grant_valid_n = grant_valid;
    timeout_n     = 1'b0;
    hold_cnt_n    = hold_cnt;
    last_id_n     = last_id;
    mask_n        = mask & req;
    case (state)
      IDLE, GAP: begin
        // The GAP cycle itself is the dead cycle, so its exit edge may grant directly.
        if (any_eligible) begin
          state_n       = BUSY;
          grant_n       = 8'h01 << winner;
          grant_id_n    = winner;
          grant_valid_n = 1'b1;
          hold_cnt_n    = 8'd0;
          last_id_n     = winner;
        end else begin
          state_n = IDLE;
        end
      end
      BUSY: begin
        if (!req[grant_id]) begin
          state_n       = GAP;
          grant_n       = 8'h00;
          grant_id_n    = 3'd0;
          grant_valid_n = 1'b0;
        end else if (hold_cnt == HOLD_LIM) begin
          state_n          = GAP;
          grant_n          = 8'h00;
          grant_id_n       = 3'd0;
          grant_valid_n    = 1'b0;
          timeout_n        = 1'b1;
          mask_n[grant_id] = 1'b1;
        end else begin
          hold_cnt_n = hold_cnt + 8'd1;
        end
      end
      default: begin
        state_n       = IDLE;
        grant_n       = 8'h00;
        grant_id_n    = 3'd0;
        grant_valid_n = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset drops any grant without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= 8'h00;
      grant_id    <= 3'd0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
      hold_cnt    <= 8'd0;
      mask        <= 8'h00;
      last_id     <= 3'd7;
    end else begin
      state       <= state_n;
      grant       <= grant_n;
      grant_id    <= grant_id_n;
      grant_valid <= grant_valid_n;
      timeout     <= timeout_n;
      hold_cnt    <= hold_cnt_n;
      mask        <= mask_n;
      last_id     <= last_id_n;
    end
  end

endmodule

// File: tb/tb_priority_arbiter8.sv
// tb/tb_priority_arbiter8.sv - self-checking bench for priority_arbiter8

module tb_priority_arbiter8;

  logic       clk;
  logic       rst_n;
  logic [7:0] req0, req1, req2;
  logic [7:0] g0, g1, g2;
  logic [2:0] id0, id1, id2;
  logic       v0, v1, v2;
  logic       to0, to1, to2;

  int checks   = 0;
  int failures = 0;

  // u0: fixed priority, hold limit 3; u1: rotation, default limit; u2: fixed, hold limit 2
  priority_arbiter8 #(.RR_EN(0), .MAX_HOLD(3)) u0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .grant(g0), .grant_id(id0),
    .grant_valid(v0), .timeout(to0));
  priority_arbiter8 #(.RR_EN(1), .MAX_HOLD(15)) u1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .grant(g1), .grant_id(id1),
    .grant_valid(v1), .timeout(to1));
  priority_arbiter8 #(.RR_EN(0), .MAX_HOLD(2)) u2 (
    .clk(clk), .rst_n(rst_n), .req(req2), .grant(g2), .grant_id(id2),
    .grant_valid(v2), .timeout(to2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state per instance: owner, cycles the grant has been visible, blocked requesters.
  int         mh [3] = '{3, 15, 2};
  int         rr [3] = '{0, 1, 0};
  int         m_gid [3];
  int         m_held [3];
  int         m_last [3];
  bit         m_valid [3];
  bit         m_to [3];
  logic [7:0] m_blk [3];

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_gid[k] = 0; m_held[k] = 0; m_last[k] = 7;
      m_valid[k] = 0; m_to[k] = 0; m_blk[k] = 8'h00;
    end
  endtask

  task automatic model_step(input int k, input logic [7:0] r);
    logic [7:0] elig;
    int pick;
    int idx;
    m_to[k] = 0;
    elig = r & ~m_blk[k];
    m_blk[k] = m_blk[k] & r;
    if (m_valid[k]) begin
      if (!r[m_gid[k]]) begin
        m_valid[k] = 0;
      end else if (m_held[k] == mh[k]) begin
        m_valid[k] = 0;
        m_to[k] = 1;
        m_blk[k][m_gid[k]] = 1'b1;
      end else begin
        m_held[k] = m_held[k] + 1;
      end
    end else begin
      pick = -1;
      for (int s = 1; s <= 8; s++) begin
        idx = rr[k] ? (m_last[k] + s) % 8 : s - 1;
        if (pick < 0 && elig[idx]) pick = idx;
      end
      if (pick >= 0) begin
        m_valid[k] = 1; m_gid[k] = pick; m_last[k] = pick; m_held[k] = 1;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else begin
      model_step(0, req0);
      model_step(1, req1);
      model_step(2, req2);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic cmp(input int k, input logic [7:0] g, input logic [2:0] id,
                     input logic v, input logic t);
    int eg, eid;
    eg  = m_valid[k] ? (1 << m_gid[k]) : 0;
    eid = m_valid[k] ? m_gid[k] : 0;
    chk($sformatf("model_grant_u%0d t=%0t", k, $time), int'(g), eg);
    chk($sformatf("model_grant_id_u%0d t=%0t", k, $time), int'(id), eid);
    chk($sformatf("model_valid_u%0d t=%0t", k, $time), int'(v), int'(m_valid[k]));
    chk($sformatf("model_timeout_u%0d t=%0t", k, $time), int'(t), int'(m_to[k]));
    chk($sformatf("onehot_u%0d t=%0t", k, $time), int'(v ? g[id] && $onehot(g) : g == 8'h00), 1);
  endtask

  always @(negedge clk) begin
    cmp(0, g0, id0, v0, to0);
    cmp(1, g1, id1, v1, to1);
    cmp(2, g2, id2, v2, to2);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    req0 = 8'h00; req1 = 8'h00; req2 = 8'h00;
    tick(); tick();
    chk("reset_valid", int'(v0), 0);
    chk("reset_grant", int'(g0), 0);
    chk("reset_id", int'(id0), 0);
    chk("reset_timeout", int'(to0), 0);
    rst_n = 1'b1;
    tick();

    // fixed priority: lowest index wins, next lowest after one dead cycle
    req0 = 8'b1010_0100;
    tick();
    chk("fixed_first_id", int'(id0), 2);
    chk("fixed_first_grant", int'(g0), 8'h04);
    req0 = 8'b1010_0000;
    tick();
    chk("fixed_gap_valid", int'(v0), 0);
    tick();
    chk("fixed_second_id", int'(id0), 5);
    chk("fixed_second_grant", int'(g0), 8'h20);
    req0 = 8'h00;
    tick(); tick();

    // no preemption by a higher-priority newcomer
    req0 = 8'h40;
    tick();
    chk("nopre_id6", int'(id0), 6);
    req0 = 8'h41;
    tick();
    chk("nopre_held6", int'(id0), 6);
    req0 = 8'h01;
    tick();
    chk("nopre_gap", int'(v0), 0);
    tick();
    chk("nopre_id0", int'(id0), 0);
    chk("nopre_valid0", int'(v0), 1);
    req0 = 8'h00;
    tick(); tick();

    // timeout after 3 held cycles; masked until req drops once
    req0 = 8'h10;
    tick(); chk("to_hold1", int'(id0), 4);
    tick(); chk("to_hold2", int'(id0), 4);
    tick(); chk("to_hold3", int'(id0), 4);
    tick();
    chk("to_pulse", int'(to0), 1);
    chk("to_released", int'(v0), 0);
    tick();
    chk("to_pulse_single", int'(to0), 0);
    chk("to_masked_a", int'(v0), 0);
    tick();
    chk("to_masked_b", int'(v0), 0);
    req0 = 8'h00;
    tick();
    req0 = 8'h10;
    tick();
    chk("to_regrant_valid", int'(v0), 1);
    chk("to_regrant_id", int'(id0), 4);
    req0 = 8'h00;
    tick(); tick();

    // asynchronous reset in the middle of a grant
    req0 = 8'h08;
    tick();
    chk("rst_mid_id3", int'(id0), 3);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", int'(v0), 0);
    chk("rst_mid_grant", int'(g0), 0);
    chk("rst_mid_id", int'(id0), 0);
    req0 = 8'h01;
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_after_valid", int'(v0), 1);
    chk("rst_after_id", int'(id0), 0);
    req0 = 8'h00;
    tick(); tick();

    // round-robin sweep 0..7,0 with one dead cycle each
    req1 = 8'hFF;
    for (int k = 0; k <= 8; k++) begin
      tick();
      chk($sformatf("rr_id_step%0d", k), int'(id1), k % 8);
      chk($sformatf("rr_valid_step%0d", k), int'(v1), 1);
      req1 = 8'hFF & ~(8'h01 << (k % 8));
      tick();
      chk($sformatf("rr_gap_step%0d", k), int'(v1), 0);
      req1 = 8'hFF;
    end
    req1 = 8'h00;
    tick(); tick();

    // release coinciding with the hold limit is a plain release
    req2 = 8'h02;
    tick(); chk("sim_hold1", int'(id2), 1);
    tick(); chk("sim_hold2", int'(id2), 1);
    req2 = 8'h00;
    tick();
    chk("sim_no_timeout", int'(to2), 0);
    chk("sim_released", int'(v2), 0);
    req2 = 8'h02;
    tick();
    chk("sim_not_masked", int'(v2), 1);
    chk("sim_not_masked_id", int'(id2), 1);
    tick();
    tick();
    chk("sim_real_timeout", int'(to2), 1);
    req2 = 8'h00;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/priority_arbiter8.md
PRIORITY_ARBITER8 -- requirements
Module: priority_arbiter8

Interface
REQ-001 SHALL have parameter RR_EN, default 0, meaning 0 = fixed priority with index 0 highest, 1 = round-robin rotation.
REQ-002 SHALL have parameter MAX_HOLD, default 15, range 1..255, meaning the maximum number of consecutive cycles one grant may be held.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port req, input, 8 bits: request lines; req[i] is requester i, held high until served.
REQ-006 SHALL have port grant, output, 8 bits: registered grant, one-hot or all-zero.
REQ-007 SHALL have port grant_id, output, 3 bits: binary index of the granted requester; 0 when no grant.
REQ-008 SHALL have port grant_valid, output, 1 bit: high iff grant is non-zero.
REQ-009 SHALL have port timeout, output, 1 bit: single-cycle pulse when a grant is force-released.

Function
REQ-010 SHALL implement states IDLE, BUSY and GAP.
REQ-011 SHALL, in IDLE with at least one eligible req bit, select a winner, load grant/grant_id/grant_valid and enter BUSY on the same edge, so grant appears 1 cycle after req is sampled.
REQ-012 SHALL stay in IDLE with all grant outputs 0 when no eligible req bit is set.
REQ-013 SHALL, with RR_EN=0, select the lowest-index eligible req bit.
REQ-014 SHALL, with RR_EN=1, search from (last_id+1) mod 8 upward with wrap-around and select the first eligible bit; last_id resets to 7, so index 0 is searched first after reset.
REQ-015 SHALL update last_id to the winner on every grant.
REQ-016 SHALL hold the grant in BUSY while req[grant_id] stays high; other req changes in BUSY SHALL NOT affect the grant (no preemption).
REQ-017 SHALL, when req[grant_id] is sampled low in BUSY, clear all grant outputs and enter GAP.
REQ-018 SHALL keep a hold counter that is cleared on grant and incremented each BUSY cycle.
REQ-019 SHALL, when the grant has been held MAX_HOLD cycles and req[grant_id] is still high, clear all grant outputs, pulse timeout for 1 cycle, set mask[grant_id], and enter GAP.
REQ-020 SHALL treat a release and a timeout in the same cycle as a normal release: no timeout pulse and no mask bit set.
REQ-021 SHALL spend exactly 1 cycle in GAP with all grant outputs 0, then enter IDLE; the minimum spacing between grants is therefore 1 dead cycle.
REQ-022 SHALL define eligible requester i as req[i] & ~mask[i].
REQ-023 SHALL clear mask[i] on any edge where req[i] is sampled low.
REQ-024 SHALL keep grant one-hot with grant[grant_id]=1 whenever grant_valid=1; this is an invariant.
REQ-025 SHALL register all outputs, with no combinational path from req to any output.

Reset
REQ-026 SHALL, on rst_n low at any time including mid-grant, immediately force state=IDLE, grant=0, grant_id=0, grant_valid=0, timeout=0, hold counter=0, mask=0 and last_id=7.
REQ-027 SHALL begin arbitration on the first rising clk edge after rst_n is sampled high.

Verification
REQ-028 SHALL cover fixed priority: RR_EN=0, req=8'b1010_0100 -> next cycle grant=8'b0000_0100, grant_id=2; drop req[2] -> GAP, then grant_id=5.
REQ-029 SHALL cover round-robin: RR_EN=1, req=8'hFF held, each requester releasing after 1 cycle -> grant_id sequence 0,1,2,...,7,0 with one 0-grant GAP cycle between grants.
REQ-030 SHALL cover timeout: MAX_HOLD=3, req[4] held high -> grant_id=4 for 3 cycles, timeout pulse, grant 0; req[4] is not regranted until it drops for at least one cycle.
REQ-031 SHALL cover no preemption: grant_id=6 active, then req[0] asserts -> grant stays at 6 until req[6] drops, then grant_id=0 after GAP.
REQ-032 SHALL cover reset mid-grant: rst_n pulled low between edges while grant_id=3 -> all outputs 0 without waiting for clk; after release with req=8'h01 -> grant_id=0.
REQ-033 SHALL cover simultaneous release and timeout: MAX_HOLD=2, req drops in the limit cycle -> timeout stays 0 and mask stays 0.
